i2c_controller_port: RTL and testbench
======================================

Name: i2c_controller_port

Overview:
- Controller-end endpoint of the I2C controller/daughter interface bundle. Owns both FIFOs the daughter handshakes against:
  - the controller-to-daughter command FIFO, which drives data and empty;
  - the daughter-to-controller response FIFO, which drives full.
- Tracks completed response packets signalled by the daughter's packet strobe.
- Instantiated inside a controller module. Presents a plain byte-write/byte-read/packet-ack port to controller logic.

Parameters:
- DEPTH_LOG2, 4, log2 of entries in each FIFO (16 bytes each).
- PKT_CNT_W, 5, width of the completed-packet counter; saturates at 2^PKT_CNT_W-1.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- interface_io  inout  `I2CIF_SIZE  bundle to daughter.
  - Block drives [15:8] cmd data, [16] rsp full, [17] cmd empty.
  - Block samples [7:0] rsp data, [18] wr, [19] rd, [20] packet.
- cmd_dat_i  in  8  command byte to queue for daughter.
- cmd_wr_i  in  1  push cmd_dat_i.
- cmd_full_o  out  1  command FIFO full.
- cmd_count_o  out  DEPTH_LOG2+1  command bytes queued.
- rsp_dat_o  out  8  head of response FIFO (first-word-fall-through).
- rsp_rd_i  in  1  pop response head.
- rsp_empty_o  out  1  response FIFO empty.
- rsp_pkt_avail_o  out  1  at least one complete response packet pending.
- rsp_pkt_ack_i  in  1  controller finished consuming one packet; decrement count.
- rsp_pkt_count_o  out  PKT_CNT_W  completed packets pending.
- err_o  out  3  sticky flags:
  - [0] cmd push while full;
  - [1] daughter wr while full;
  - [2] packet counter saturated, or ack at zero.
- err_clr_i  in  1  clear err_o.

Behaviour:
- Reset (rst_n_i=0 at an edge): both FIFOs emptied, pointers and counts 0.
  - cmd empty ([17])=1, rsp full ([16])=0, cmd_full_o=0, rsp_empty_o=1.
  - rsp_pkt_count_o=0, rsp_pkt_avail_o=0, err_o=0.
  - [15:8] and rsp_dat_o are don't-care while empty.
  - Reset mid-transfer discards all queued bytes and packet counts; no partial completion.
- FIFO structure: dual-pointer circular buffers with (DEPTH_LOG2+1)-bit pointers; MSB distinguishes full from empty. Pointer wrap at 2^DEPTH_LOG2 is seamless.
- Command FIFO, FWFT toward daughter:
  - cmd_wr_i at edge N with not full: byte stored; cmd empty deasserts and [15:8] shows the byte from N+1.
  - Daughter rd ([19]) at edge N with not empty pops the head; the next byte is presented at N+1.
  - rd while empty is ignored (no error; the daughter is responsible).
  - Push while full: dropped, err_o[0] set.
  - Full FIFO with simultaneous push and pop: pop accepted, push dropped and flagged (full is checked pre-edge).
  - Empty FIFO with simultaneous push and pop: push accepted, pop ignored.
- Response FIFO:
  - Daughter wr ([18]) with full=0 stores [7:0].
  - wr while full: byte dropped, err_o[1] set. Full FIFO with simultaneous wr and rsp_rd_i: pop only.
  - rsp_dat_o is the head, valid whenever rsp_empty_o=0. rsp_rd_i pops; next head at N+1.
  - rsp_rd_i while empty is ignored.
- Packet tracking:
  - packet ([20]) high for one cycle marks end of a response packet.
  - If wr and packet are coincident, that byte belongs to the closing packet.
  - A packet strobe with zero bytes still counts as one (empty packet).
  - Counter update per edge:
    - +1 on packet alone;
    - -1 on rsp_pkt_ack_i alone;
    - unchanged when both occur.
  - Increment at max: holds, err_o[2] set. Ack at 0: holds, err_o[2] set.
  - rsp_pkt_avail_o = (count != 0), registered with the counter (same cycle as count).
  - The block does not enforce that acked packets' bytes have been read; the controller owns the byte/packet correspondence.
- cmd_count_o and the response full flag are registered and update one edge after the causing event, consistent with the FIFO pointers.
- err_o bits are sticky until err_clr_i. If err_clr_i coincides with a new error event, set wins.
- Throughput: one byte per cycle in each direction simultaneously; no bubbles.

Test Plan:
- Reset, then push 0xA5, 0x3C at cycles 1-2; daughter rd at cycles 4-5 -> [17] low from cycle 2; [15:8]=0xA5 then 0x3C; [17] high after cycle 5 pop; cmd_count_o 0→1→2→1→0.
- Push 17 bytes (0x00-0x10) with no daughter reads -> cmd_full_o high after 16th push; 0x10 dropped; err_o[0]=1; daughter drains exactly 0x00-0x0F in order across pointer wrap.
- Daughter writes 0x11, 0x22, 0x33, with packet coincident on 0x33; then a bare packet strobe -> rsp_pkt_count_o=2, rsp_pkt_avail_o=1; controller reads 0x11, 0x22, 0x33; rsp_empty_o=1; two acks -> count 0.
- Simultaneous packet and rsp_pkt_ack_i with count=1 -> count stays 1, no error; ack at count 0 -> err_o[2]=1, count 0; err_clr_i -> err_o=0.
- Fill response FIFO with 16 daughter writes, then wr together with rsp_rd_i -> head popped, new byte dropped, err_o[1]=1, [16] drops next cycle.
- Assert rst_n_i low with 5 bytes queued each way and count=1 -> next cycle both FIFOs empty, [17]=1, [16]=0, count 0, err_o 0.

Source files
------------

// File: rtl/i2c_controller_port.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_controller_port
//  Description : Controller-end endpoint of the I2C controller/daughter
//                bundle. Owns the command FIFO (controller -> daughter, FWFT)
//                and the response FIFO (daughter -> controller, FWFT). It also
//                counts completed response packets and keeps sticky error
//                flags.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef I2CIF_SIZE
`define I2CIF_SIZE 21
`endif

module i2c_controller_port #(
    parameter int DEPTH_LOG2 = 4,
    parameter int PKT_CNT_W  = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    inout  wire  [`I2CIF_SIZE-1:0]  interface_io,
    input  logic [7:0]              cmd_dat_i,
    input  logic                    cmd_wr_i,
    output logic                    cmd_full_o,
    output logic [DEPTH_LOG2:0]     cmd_count_o,
    output logic [7:0]              rsp_dat_o,
    input  logic                    rsp_rd_i,
    output logic                    rsp_empty_o,
    output logic                    rsp_pkt_avail_o,
    input  logic                    rsp_pkt_ack_i,
    output logic [PKT_CNT_W-1:0]    rsp_pkt_count_o,
    output logic [2:0]              err_o,
    input  logic                    err_clr_i
);

    localparam int                   c_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [PKT_CNT_W-1:0] c_PKT_MAX = {PKT_CNT_W{1'b1}};

    // Daughter-side strobes and data sampled from the bundle
    logic [7:0] w_d_dat;
    logic       w_d_wr;
    logic       w_d_rd;
    logic       w_d_pkt;

    assign w_d_dat = interface_io[7:0];
    assign w_d_wr  = interface_io[18];
    assign w_d_rd  = interface_io[19];
    assign w_d_pkt = interface_io[20];

    // ------------------------------------------------------------------
    // Command FIFO (controller pushes, daughter pops)
    // ------------------------------------------------------------------
    logic [7:0]        r_cmd_mem [c_DEPTH];
    logic [DEPTH_LOG2:0] r_cmd_wptr;
    logic [DEPTH_LOG2:0] r_cmd_rptr;
    logic              w_cmd_full;
    logic              w_cmd_empty;
    logic              w_cmd_push;
    logic              w_cmd_pop;

    // Extra pointer MSB separates the full case from the empty case
    assign w_cmd_empty = (r_cmd_wptr == r_cmd_rptr);
    assign w_cmd_full  = (r_cmd_wptr[DEPTH_LOG2] != r_cmd_rptr[DEPTH_LOG2]) &&
                         (r_cmd_wptr[DEPTH_LOG2-1:0] == r_cmd_rptr[DEPTH_LOG2-1:0]);
    // Full/empty are judged on pre-edge state, so a push into a full FIFO
    // is dropped even if the daughter pops on the same edge
    assign w_cmd_push  = cmd_wr_i && !w_cmd_full;
    assign w_cmd_pop   = w_d_rd && !w_cmd_empty;

    // Command storage write port
    always_ff @(posedge clk_i) begin
        if (w_cmd_push) begin
            r_cmd_mem[r_cmd_wptr[DEPTH_LOG2-1:0]] <= cmd_dat_i;
        end
    end

    // Command pointers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_cmd_wptr <= '0;
            r_cmd_rptr <= '0;
        end else begin
            if (w_cmd_push) r_cmd_wptr <= r_cmd_wptr + 1'b1;
            if (w_cmd_pop)  r_cmd_rptr <= r_cmd_rptr + 1'b1;
        end
    end

    assign cmd_full_o  = w_cmd_full;
    assign cmd_count_o = r_cmd_wptr - r_cmd_rptr;

    // ------------------------------------------------------------------
    // Response FIFO (daughter pushes, controller pops)
    // ------------------------------------------------------------------
    logic [7:0]        r_rsp_mem [c_DEPTH];
    logic [DEPTH_LOG2:0] r_rsp_wptr;
    logic [DEPTH_LOG2:0] r_rsp_rptr;
    logic              w_rsp_full;
    logic              w_rsp_empty;
    logic              w_rsp_push;
    logic              w_rsp_pop;

    assign w_rsp_empty = (r_rsp_wptr == r_rsp_rptr);
    assign w_rsp_full  = (r_rsp_wptr[DEPTH_LOG2] != r_rsp_rptr[DEPTH_LOG2]) &&
                         (r_rsp_wptr[DEPTH_LOG2-1:0] == r_rsp_rptr[DEPTH_LOG2-1:0]);
    assign w_rsp_push  = w_d_wr && !w_rsp_full;
    assign w_rsp_pop   = rsp_rd_i && !w_rsp_empty;

    // Response storage write port
    always_ff @(posedge clk_i) begin
        if (w_rsp_push) begin
            r_rsp_mem[r_rsp_wptr[DEPTH_LOG2-1:0]] <= w_d_dat;
        end
    end

    // Response pointers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rsp_wptr <= '0;
            r_rsp_rptr <= '0;
        end else begin
            if (w_rsp_push) r_rsp_wptr <= r_rsp_wptr + 1'b1;
            if (w_rsp_pop)  r_rsp_rptr <= r_rsp_rptr + 1'b1;
        end
    end

    assign rsp_dat_o   = r_rsp_mem[r_rsp_rptr[DEPTH_LOG2-1:0]];
    assign rsp_empty_o = w_rsp_empty;

    // ------------------------------------------------------------------
    // Completed-packet counter
    // ------------------------------------------------------------------
    logic [PKT_CNT_W-1:0] r_pkt_cnt;
    logic                 r_pkt_avail;
    logic [PKT_CNT_W-1:0] w_pkt_cnt_nxt;
    logic                 w_pkt_err;

    // Next count: strobe and ack on the same edge cancel; overflow and
    // underflow hold the count and raise the packet error
    always_comb begin
        w_pkt_cnt_nxt = r_pkt_cnt;
        w_pkt_err     = 1'b0;
        if (w_d_pkt && !rsp_pkt_ack_i) begin
            if (r_pkt_cnt == c_PKT_MAX) w_pkt_err = 1'b1;
            else                        w_pkt_cnt_nxt = r_pkt_cnt + 1'b1;
        end else if (rsp_pkt_ack_i && !w_d_pkt) begin
            if (r_pkt_cnt == '0) w_pkt_err = 1'b1;
            else                 w_pkt_cnt_nxt = r_pkt_cnt - 1'b1;
        end
    end

    // Counter and its non-zero flag are registered together
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_pkt_cnt   <= '0;
            r_pkt_avail <= 1'b0;
        end else begin
            r_pkt_cnt   <= w_pkt_cnt_nxt;
            r_pkt_avail <= (w_pkt_cnt_nxt != '0);
        end
    end

    assign rsp_pkt_count_o = r_pkt_cnt;
    assign rsp_pkt_avail_o = r_pkt_avail;

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic [2:0] r_err;
    logic [2:0] w_err_set;

    assign w_err_set = {w_pkt_err, (w_d_wr && w_rsp_full), (cmd_wr_i && w_cmd_full)};

    // Clear applies first so a coincident new error still lands
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_err <= '0;
        end else begin
            r_err <= (err_clr_i ? 3'b000 : r_err) | w_err_set;
        end
    end

    assign err_o = r_err;

    // ------------------------------------------------------------------
    // Bundle outputs toward the daughter
    // ------------------------------------------------------------------
    assign interface_io[15:8] = r_cmd_mem[r_cmd_rptr[DEPTH_LOG2-1:0]];
    assign interface_io[16]   = w_rsp_full;
    assign interface_io[17]   = w_cmd_empty;

endmodule

`default_nettype wire

// File: tb/tb_i2c_controller_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_controller_port
//  Description : Directed self-checking bench for i2c_controller_port.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef I2CIF_SIZE
`define I2CIF_SIZE 21
`endif

module tb_i2c_controller_port;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cmd_dat;
    logic       cmd_wr;
    logic       cmd_full;
    logic [4:0] cmd_count;
    logic [7:0] rsp_dat;
    logic       rsp_rd;
    logic       rsp_empty;
    logic       pkt_avail;
    logic       pkt_ack;
    logic [4:0] pkt_count;
    logic [2:0] err;
    logic       err_clr;

    // Daughter-side model drive
    logic [7:0] d_dat;
    logic       d_wr;
    logic       d_rd;
    logic       d_pkt;

    wire [`I2CIF_SIZE-1:0] bus;
    assign bus[7:0] = d_dat;
    assign bus[18]  = d_wr;
    assign bus[19]  = d_rd;
    assign bus[20]  = d_pkt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    i2c_controller_port #(
        .DEPTH_LOG2 (4),
        .PKT_CNT_W  (5)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .interface_io    (bus),
        .cmd_dat_i       (cmd_dat),
        .cmd_wr_i        (cmd_wr),
        .cmd_full_o      (cmd_full),
        .cmd_count_o     (cmd_count),
        .rsp_dat_o       (rsp_dat),
        .rsp_rd_i        (rsp_rd),
        .rsp_empty_o     (rsp_empty),
        .rsp_pkt_avail_o (pkt_avail),
        .rsp_pkt_ack_i   (pkt_ack),
        .rsp_pkt_count_o (pkt_count),
        .err_o           (err),
        .err_clr_i       (err_clr)
    );

    // Advance one rising edge, then settle before checking or driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0; cmd_dat = '0; cmd_wr = 1'b0; rsp_rd = 1'b0;
        pkt_ack = 1'b0; err_clr = 1'b0;
        d_dat = '0; d_wr = 1'b0; d_rd = 1'b0; d_pkt = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_cmd_empty", 32'(bus[17]), 1);
        check("rst_rsp_full",  32'(bus[16]), 0);
        check("rst_cmd_full",  32'(cmd_full), 0);
        check("rst_rsp_empty", 32'(rsp_empty), 1);
        check("rst_cmd_count", 32'(cmd_count), 0);
        check("rst_pkt_count", 32'(pkt_count), 0);
        check("rst_pkt_avail", 32'(pkt_avail), 0);
        check("rst_err",       32'(err), 0);

        // Two command bytes, then daughter pops them
        cmd_wr = 1'b1; cmd_dat = 8'hA5; tick();
        check("c1_empty", 32'(bus[17]), 0);
        check("c1_head",  32'(bus[15:8]), 32'hA5);
        check("c1_count", 32'(cmd_count), 1);
        cmd_dat = 8'h3C; tick();
        cmd_wr = 1'b0;
        check("c2_head",  32'(bus[15:8]), 32'hA5);
        check("c2_count", 32'(cmd_count), 2);
        tick();
        d_rd = 1'b1; tick();
        check("c3_head",  32'(bus[15:8]), 32'h3C);
        check("c3_count", 32'(cmd_count), 1);
        tick();
        d_rd = 1'b0;
        check("c4_empty", 32'(bus[17]), 1);
        check("c4_count", 32'(cmd_count), 0);

        // Overfill the command FIFO (pointers start at 2, so this wraps)
        cmd_wr = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cmd_dat = 8'(i);
            tick();
            if (i == 15) check("fill_full16", 32'(cmd_full), 1);
        end
        cmd_wr = 1'b0;
        check("fill_count", 32'(cmd_count), 16);
        check("fill_err0",  32'(err), 32'b001);
        d_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_head", 32'(bus[15:8]), 32'(i));
            tick();
        end
        d_rd = 1'b0;
        check("drain_empty", 32'(bus[17]), 1);
        check("drain_count", 32'(cmd_count), 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("clr_err0", 32'(err), 0);

        // Response packet of three bytes plus an empty packet
        d_wr = 1'b1; d_dat = 8'h11; tick();
        d_dat = 8'h22; tick();
        d_dat = 8'h33; d_pkt = 1'b1; tick();
        d_wr = 1'b0; tick();
        d_pkt = 1'b0;
        check("pkt_count2", 32'(pkt_count), 2);
        check("pkt_avail",  32'(pkt_avail), 1);
        check("rsp_head0",  32'(rsp_dat), 32'h11);
        rsp_rd = 1'b1; tick();
        check("rsp_head1",  32'(rsp_dat), 32'h22);
        tick();
        check("rsp_head2",  32'(rsp_dat), 32'h33);
        tick();
        rsp_rd = 1'b0;
        check("rsp_empty",  32'(rsp_empty), 1);
        pkt_ack = 1'b1; tick();
        check("ack_count1", 32'(pkt_count), 1);
        tick();
        pkt_ack = 1'b0;
        check("ack_count0", 32'(pkt_count), 0);
        check("ack_avail0", 32'(pkt_avail), 0);
        check("ack_err",    32'(err), 0);

        // Coincident strobe/ack, then ack at zero
        d_pkt = 1'b1; tick();
        check("co_pre", 32'(pkt_count), 1);
        pkt_ack = 1'b1; tick();
        d_pkt = 1'b0;
        check("co_count", 32'(pkt_count), 1);
        check("co_err",   32'(err), 0);
        tick();
        check("co_dec",   32'(pkt_count), 0);
        tick();
        pkt_ack = 1'b0;
        check("uf_count", 32'(pkt_count), 0);
        check("uf_err2",  32'(err), 32'b100);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("clr_err2", 32'(err), 0);

        // Fill response FIFO, then write and read together while full
        d_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d_dat = 8'(8'h40 + i);
            tick();
        end
        check("rf_full", 32'(bus[16]), 1);
        d_dat = 8'hEE; rsp_rd = 1'b1; tick();
        d_wr = 1'b0; rsp_rd = 1'b0;
        check("rf_err1",  32'(err), 32'b010);
        check("rf_nfull", 32'(bus[16]), 0);
        check("rf_head",  32'(rsp_dat), 32'h41);
        rsp_rd = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("rf_drain", 32'(rsp_dat), 32'(8'h40 + i));
            tick();
        end
        rsp_rd = 1'b0;
        check("rf_empty", 32'(rsp_empty), 1);

        // Queue five bytes each way and one packet, then reset
        cmd_wr = 1'b1; d_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_dat = 8'(8'h70 + i);
            d_dat   = 8'(8'h80 + i);
            d_pkt   = (i == 4);
            tick();
        end
        cmd_wr = 1'b0; d_wr = 1'b0; d_pkt = 1'b0;
        check("pre_cmd_count", 32'(cmd_count), 5);
        check("pre_pkt_count", 32'(pkt_count), 1);
        check("pre_rsp_empty", 32'(rsp_empty), 0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("mr_cmd_empty", 32'(bus[17]), 1);
        check("mr_rsp_full",  32'(bus[16]), 0);
        check("mr_rsp_empty", 32'(rsp_empty), 1);
        check("mr_cmd_count", 32'(cmd_count), 0);
        check("mr_pkt_count", 32'(pkt_count), 0);
        check("mr_pkt_avail", 32'(pkt_avail), 0);
        check("mr_err",       32'(err), 0);
        tick();
        check("mr_hold_empty", 32'(rsp_empty), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
